// File: rtl/apb2axi_pkg.sv
// apb2axi_pkg: shared types and defaults for the APB-to-AXI completion queue
package apb2axi_pkg;
  localparam int TAG_NUM = 8;
  localparam int TAG_W = $clog2(TAG_NUM);
  localparam int CQ_DEPTH = 4;
  localparam int BEAT_W = 9;
  typedef enum logic [1:0] {
    RESP_OKAY   = 2'd0,
    RESP_EXOKAY = 2'd1,
    RESP_SLVERR = 2'd2,
    RESP_DECERR = 2'd3
  } axi_resp_e;
  typedef struct packed {
    logic [TAG_W-1:0]  tag;
    logic [1:0]        resp;
    logic [BEAT_W-1:0] num_beats;
    logic              error;
    logic [BEAT_W-1:0] err_beat_idx;
  } completion_entry_t;
endpackage

// File: rtl/apb2axi_completion_queue_if.sv
// apb2axi_completion_queue_if: response-beat input and directory completion output bundle
interface apb2axi_completion_queue_if;
  import apb2axi_pkg::*;
  logic              rsp_cq_vld;
  logic [TAG_W-1:0]  rsp_cq_tag;
  logic [1:0]        rsp_cq_resp;
  logic              rsp_cq_last;
  logic              rsp_cq_rdy;
  logic              cq_dir_cpl_vld;
  completion_entry_t cq_dir_cpl_entry;
  logic              cq_dir_cpl_rdy;
  logic [15:0]       cq_cpl_count;
  logic [15:0]       cq_err_count;
  modport slave (
    input  rsp_cq_vld, rsp_cq_tag, rsp_cq_resp, rsp_cq_last, cq_dir_cpl_rdy,
    output rsp_cq_rdy, cq_dir_cpl_vld, cq_dir_cpl_entry, cq_cpl_count, cq_err_count
  );
  modport master (
    output rsp_cq_vld, rsp_cq_tag, rsp_cq_resp, rsp_cq_last, cq_dir_cpl_rdy,
    input  rsp_cq_rdy, cq_dir_cpl_vld, cq_dir_cpl_entry, cq_cpl_count, cq_err_count
  );
endinterface

// File: rtl/apb2axi_cq_fifo.sv
// apb2axi_cq_fifo: synchronous show-ahead FIFO; head reads as zero while empty
module apb2axi_cq_fifo #(
  parameter type T = logic [7:0],
  parameter int DEPTH = 4
) (
  input  logic pclk,
  input  logic preset,
  input  logic push,
  input  T     din,
  output logic full,
  input  logic pop,
  output logic empty,
  output T     dout
);
  localparam int AW = $clog2(DEPTH);
  T mem [DEPTH];
  logic [AW-1:0] wr, rd;
  logic [AW:0] cnt;
  logic do_push, do_pop;
  assign full = cnt == (AW+1)'(DEPTH);
  assign empty = cnt == '0;
  assign do_push = push && !full;
  assign do_pop = pop && !empty;
  assign dout = empty ? '0 : mem[rd];
  always_ff @(posedge pclk)
    if (do_push) mem[wr] <= din;
  always_ff @(posedge pclk) begin
    if (preset) begin
      wr <= '0;
      rd <= '0;
      cnt <= '0;
    end else begin
      if (do_push) wr <= wr + 1'b1;
      if (do_pop) rd <= rd + 1'b1;
      cnt <= cnt + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end
  end
endmodule

// File: rtl/apb2axi_completion_queue.sv
// apb2axi_completion_queue: merges per-tag AXI response beats into completions for the directory
// Optional stats counters enabled by APB2AXI_CQ_STATS_EN.
module apb2axi_completion_queue #(
  parameter int CQ_DEPTH = apb2axi_pkg::CQ_DEPTH
) (
  input logic pclk,
  input logic preset,
  apb2axi_completion_queue_if.slave bus
);
  import apb2axi_pkg::*;
  logic [BEAT_W-1:0] beats [TAG_NUM];
  logic [1:0] worst [TAG_NUM];
  logic err_seen [TAG_NUM];
  logic [BEAT_W-1:0] err_idx [TAG_NUM];
  logic full, empty, acc;
  logic [BEAT_W-1:0] cur, nxt_beats, new_idx;
  logic [1:0] new_worst;
  logic new_err;
  completion_entry_t ent;
  assign bus.rsp_cq_rdy = !full;
  assign bus.cq_dir_cpl_vld = !empty;
  assign acc = bus.rsp_cq_vld && !full;
  always_comb begin
    cur = beats[bus.rsp_cq_tag];
    nxt_beats = &cur ? cur : cur + 1'b1;
    new_worst = bus.rsp_cq_resp > worst[bus.rsp_cq_tag] ? bus.rsp_cq_resp : worst[bus.rsp_cq_tag];
    new_err = err_seen[bus.rsp_cq_tag] | bus.rsp_cq_resp[1];
    new_idx = err_seen[bus.rsp_cq_tag] ? err_idx[bus.rsp_cq_tag] : bus.rsp_cq_resp[1] ? cur : '0;
    ent = '{tag: bus.rsp_cq_tag, resp: new_worst, num_beats: nxt_beats, error: new_err, err_beat_idx: new_idx};
  end
  // the last beat both emits the merged entry and frees the tag for reuse
  always_ff @(posedge pclk) begin
    if (preset) begin
      beats <= '{default: '0};
      worst <= '{default: '0};
      err_seen <= '{default: 1'b0};
      err_idx <= '{default: '0};
    end else if (acc) begin
      beats[bus.rsp_cq_tag] <= bus.rsp_cq_last ? '0 : nxt_beats;
      worst[bus.rsp_cq_tag] <= bus.rsp_cq_last ? '0 : new_worst;
      err_seen[bus.rsp_cq_tag] <= !bus.rsp_cq_last && new_err;
      err_idx[bus.rsp_cq_tag] <= bus.rsp_cq_last ? '0 : new_idx;
    end
  end
  assert property (@(posedge pclk) disable iff (preset) acc |-> !(&cur));
  apb2axi_cq_fifo #(.T(completion_entry_t), .DEPTH(CQ_DEPTH)) u_fifo (
    .pclk   (pclk),
    .preset (preset),
    .push   (acc && bus.rsp_cq_last),
    .din    (ent),
    .full   (full),
    .pop    (bus.cq_dir_cpl_rdy),
    .empty  (empty),
    .dout   (bus.cq_dir_cpl_entry)
  );
`ifdef APB2AXI_CQ_STATS_EN
  logic [15:0] cpl_cnt, err_cnt;
  always_ff @(posedge pclk) begin
    if (preset) begin
      cpl_cnt <= '0;
      err_cnt <= '0;
    end else if (!empty && bus.cq_dir_cpl_rdy) begin
      cpl_cnt <= &cpl_cnt ? cpl_cnt : cpl_cnt + 1'b1;
      err_cnt <= (bus.cq_dir_cpl_entry.error && !(&err_cnt)) ? err_cnt + 1'b1 : err_cnt;
    end
  end
  assign bus.cq_cpl_count = cpl_cnt;
  assign bus.cq_err_count = err_cnt;
`else
  assign bus.cq_cpl_count = '0;
  assign bus.cq_err_count = '0;
`endif
endmodule

// File: tb/tb_apb2axi_completion_queue.sv
// tb_apb2axi_completion_queue: directed self-checking bench for the completion queue
module tb_apb2axi_completion_queue;
  import apb2axi_pkg::*;
  logic pclk = 0, preset = 1;
  int n_tests = 0, n_fail = 0;
  apb2axi_completion_queue_if bus();
  apb2axi_completion_queue dut (.pclk(pclk), .preset(preset), .bus(bus));
  always #5 pclk = ~pclk;
  task automatic chk(string name, logic [31:0] got, logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask
  function automatic logic [31:0] ent(int t, int r, int n, int e, int i);
    completion_entry_t c;
    c.tag = TAG_W'(t);
    c.resp = 2'(r);
    c.num_beats = BEAT_W'(n);
    c.error = 1'(e);
    c.err_beat_idx = BEAT_W'(i);
    return 32'(c);
  endfunction
  task automatic send(int t, int r, int l);
    int w = 0;
    bus.rsp_cq_vld = 1;
    bus.rsp_cq_tag = TAG_W'(t);
    bus.rsp_cq_resp = 2'(r);
    bus.rsp_cq_last = 1'(l);
    while (!bus.rsp_cq_rdy && w < 50) begin
      @(posedge pclk); #1;
      w++;
    end
    if (w >= 50) chk("send_timeout", 32'(bus.rsp_cq_rdy), 32'd1);
    @(posedge pclk); #1;
    bus.rsp_cq_vld = 0;
  endtask
  task automatic pop(string name, logic [31:0] exp);
    chk(name, 32'(bus.cq_dir_cpl_vld), 32'd1);
    chk(name, 32'(bus.cq_dir_cpl_entry), exp);
    bus.cq_dir_cpl_rdy = 1;
    @(posedge pclk); #1;
    bus.cq_dir_cpl_rdy = 0;
  endtask
  initial begin
    #500000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1);
  end
  initial begin
    int q[$];
    int tg;
    int rr[4] = '{0, 2, 0, 3};
    bus.rsp_cq_vld = 0;
    bus.rsp_cq_tag = '0;
    bus.rsp_cq_resp = '0;
    bus.rsp_cq_last = 0;
    bus.cq_dir_cpl_rdy = 0;
    repeat (2) @(posedge pclk);
    #1 preset = 0;
    chk("rst_rdy", 32'(bus.rsp_cq_rdy), 32'd1);
    chk("rst_vld", 32'(bus.cq_dir_cpl_vld), 32'd0);
    chk("rst_entry", 32'(bus.cq_dir_cpl_entry), 32'd0);
    chk("rst_cpl_cnt", 32'(bus.cq_cpl_count), 32'd0);
    chk("rst_err_cnt", 32'(bus.cq_err_count), 32'd0);
    // four OKAY beats on tag 3
    for (int i = 0; i < 3; i++) send(3, 0, 0);
    chk("t1_novld", 32'(bus.cq_dir_cpl_vld), 32'd0);
    send(3, 0, 1);
    pop("t1_cpl", ent(3, 0, 4, 0, 0));
    chk("t1_empty", 32'(bus.cq_dir_cpl_vld), 32'd0);
    // eight beats on tag 1, SLVERR at beats 2 and 5
    for (int i = 0; i < 8; i++) send(1, (i == 2 || i == 5) ? 2 : 0, int'(i == 7));
    pop("t2_cpl", ent(1, 2, 8, 1, 2));
    // interleaved tags 0 and 2, tag 2 ends first with DECERR on its last beat
    send(0, 0, 0);
    send(2, 0, 0);
    send(0, 1, 0);
    send(2, 3, 1);
    send(0, 0, 1);
    pop("t3_tag2", ent(2, 3, 2, 1, 1));
    pop("t3_tag0", ent(0, 1, 3, 0, 0));
    // fill the FIFO with stalled directory, fifth B response waits for a pop
    for (int t = 4; t < 8; t++) send(t, rr[t-4], 1);
    chk("t4_full_rdy", 32'(bus.rsp_cq_rdy), 32'd0);
    fork
      send(0, 0, 1);
      begin
        repeat (3) begin
          @(posedge pclk); #1;
        end
        chk("t4_stall_rdy", 32'(bus.rsp_cq_rdy), 32'd0);
        chk("t4_stable", 32'(bus.cq_dir_cpl_entry), ent(4, 0, 1, 0, 0));
        pop("t4_tag4", ent(4, 0, 1, 0, 0));
      end
    join
    pop("t4_tag5", ent(5, 2, 1, 1, 0));
    pop("t4_tag6", ent(6, 0, 1, 0, 0));
    pop("t4_tag7", ent(7, 3, 1, 1, 0));
    pop("t4_tag0", ent(0, 0, 1, 0, 0));
    chk("t4_empty", 32'(bus.cq_dir_cpl_vld), 32'd0);
    // simultaneous push and pop at three entries, ten times around the ring
    for (int t = 0; t < 3; t++) begin
      send(t, 0, 1);
      q.push_back(t);
    end
    for (int i = 0; i < 10; i++) begin
      tg = (3 + i) % 8;
      bus.rsp_cq_vld = 1;
      bus.rsp_cq_tag = TAG_W'(tg);
      bus.rsp_cq_resp = 2'd0;
      bus.rsp_cq_last = 1;
      bus.cq_dir_cpl_rdy = 1;
      chk("t5_rdy", 32'(bus.rsp_cq_rdy), 32'd1);
      chk("t5_head", 32'(bus.cq_dir_cpl_entry), ent(q[0], 0, 1, 0, 0));
      @(posedge pclk); #1;
      bus.rsp_cq_vld = 0;
      bus.cq_dir_cpl_rdy = 0;
      void'(q.pop_front());
      q.push_back(tg);
    end
    while (q.size() > 0) pop("t5_drain", ent(q.pop_front(), 0, 1, 0, 0));
    chk("t5_empty", 32'(bus.cq_dir_cpl_vld), 32'd0);
    // reset with queued entries and a half-built tag 5
    send(0, 2, 1);
    send(1, 0, 1);
    send(5, 0, 0);
    send(5, 0, 0);
    preset = 1;
    @(posedge pclk); #1;
    preset = 0;
    chk("t6_vld", 32'(bus.cq_dir_cpl_vld), 32'd0);
    chk("t6_rdy", 32'(bus.rsp_cq_rdy), 32'd1);
    chk("t6_entry", 32'(bus.cq_dir_cpl_entry), 32'd0);
    chk("t6_cpl_cnt0", 32'(bus.cq_cpl_count), 32'd0);
    chk("t6_err_cnt0", 32'(bus.cq_err_count), 32'd0);
    send(5, 0, 1);
    send(6, 2, 1);
    send(7, 0, 1);
    pop("t6_tag5", ent(5, 0, 1, 0, 0));
    pop("t6_tag6", ent(6, 2, 1, 1, 0));
    pop("t6_tag7", ent(7, 0, 1, 0, 0));
    chk("t6_empty", 32'(bus.cq_dir_cpl_vld), 32'd0);
`ifdef APB2AXI_CQ_STATS_EN
    chk("t6_cpl_cnt", 32'(bus.cq_cpl_count), 32'd3);
    chk("t6_err_cnt", 32'(bus.cq_err_count), 32'd1);
`else
    chk("t6_cpl_cnt", 32'(bus.cq_cpl_count), 32'd0);
    chk("t6_err_cnt", 32'(bus.cq_err_count), 32'd0);
`endif
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
